// File: rtl/picosoc_gpio.sv
// picosoc_gpio: WIDTH-pin GPIO for the PicoSoC iomem bus with per-bit output enable and synchronised inputs.
// Define PICOSOC_GPIO_IRQ_EN to build the per-bit edge-triggered interrupt logic (IRQ_EN/IRQ_EDGE/IRQ_STATUS).
module picosoc_gpio #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_OUT        = 3'd0,
        REG_OE         = 3'd1,
        REG_IN         = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_IRQ_EDGE   = 3'd4,
        REG_IRQ_STATUS = 3'd5,
        REG_RSVD6      = 3'd6,
        REG_RSVD7      = 3'd7
    } reg_idx_t;

    logic             sel;
    logic             is_write;
    reg_idx_t         idx;
    logic [31:0]      byte_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [31:0]      rd_value;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // The !iomem_ready term blocks re-selection in the acknowledge cycle.
    assign sel       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign is_write  = |iomem_wstrb;
    assign idx       = reg_idx_t'(iomem_addr[4:2]);
    assign byte_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                        {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wmask     = byte_mask[WIDTH-1:0];
    assign wbits     = iomem_wdata[WIDTH-1:0];

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, byte_mask};

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_val);
        return (old_val & ~wmask) | (wbits & wmask);
    endfunction

    // NOTE: the synchroniser is a handful of flops, not a RAM, so every stage is reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign in_q = sync_q[SYNC_STAGES-1];

`ifdef PICOSOC_GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] irq_edge_q;
    logic [WIDTH-1:0] irq_status_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] w1c;

    assign edges = (irq_edge_q & in_q & ~prev_q) | (~irq_edge_q & ~in_q & prev_q);
    assign w1c   = (sel && is_write && idx == REG_IRQ_STATUS) ? (wbits & wmask) : '0;
    assign irq   = |(irq_status_q & irq_en_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q     <= '0;
            irq_edge_q   <= '0;
            irq_status_q <= '0;
            prev_q       <= '0;
        end else begin
            prev_q <= in_q;
            // OR-ing the new edges in after the clear makes a coincident set win.
            irq_status_q <= (irq_status_q & ~w1c) | (edges & irq_en_q);
            if (sel && is_write) begin
                if (idx == REG_IRQ_EN)   irq_en_q   <= merge(irq_en_q);
                if (idx == REG_IRQ_EDGE) irq_edge_q <= merge(irq_edge_q);
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

    // NOTE: rd_value gets a default first so no path through the case infers a latch.
    always_comb begin
        rd_value = '0;
        case (idx)
            REG_OUT:        rd_value = 32'(out_q);
            REG_OE:         rd_value = 32'(oe_q);
            REG_IN:         rd_value = 32'(in_q);
`ifdef PICOSOC_GPIO_IRQ_EN
            REG_IRQ_EN:     rd_value = 32'(irq_en_q);
            REG_IRQ_EDGE:   rd_value = 32'(irq_edge_q);
            REG_IRQ_STATUS: rd_value = 32'(irq_status_q);
`endif
            default:        rd_value = '0;
        endcase
    end

    // NOTE: non-blocking assignments let rdata capture the pre-write register value on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            out_q       <= '0;
            oe_q        <= '0;
        end else begin
            iomem_ready <= sel;
            if (sel) begin
                iomem_rdata <= rd_value;
                if (is_write) begin
                    if (idx == REG_OUT) out_q <= merge(out_q);
                    if (idx == REG_OE)  oe_q  <= merge(oe_q);
                end
            end
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_picosoc_gpio.sv
// Directed bench for picosoc_gpio: a 32-bit and an 8-bit instance on separate request lines.
// Interrupt checks follow PICOSOC_GPIO_IRQ_EN as seen when this file is compiled.
module tb_picosoc_gpio;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid, valid8;
    logic [3:0]  strb;
    logic [31:0] addr, wdata;
    logic [31:0] gpio_in;
    logic [7:0]  gpio_in8;

    logic        ready, ready8, irq, irq8;
    logic [31:0] rdata, rdata8, gout, goe;
    logic [7:0]  gout8, goe8;
    logic [31:0] rd;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    picosoc_gpio #(.WIDTH(32), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .iomem_valid(valid), .iomem_ready(ready),
        .iomem_wstrb(strb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata),
        .gpio_in(gpio_in), .gpio_out(gout), .gpio_oe(goe), .irq(irq)
    );

    picosoc_gpio #(.WIDTH(8), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .iomem_valid(valid8), .iomem_ready(ready8),
        .iomem_wstrb(strb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata8),
        .gpio_in(gpio_in8), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One bus transaction; ready must be high exactly in the cycle after the request.
    task automatic bus(input bit on8, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input string tag, output logic [31:0] r);
        @(negedge clk);
        addr = a; strb = s; wdata = d;
        if (on8) valid8 = 1'b1; else valid = 1'b1;
        @(posedge clk); #1;
        check({tag, " ready"}, on8 ? ready8 : ready, 1);
        r = on8 ? rdata8 : rdata;
        valid = 1'b0; valid8 = 1'b0;
        @(posedge clk); #1;
        check({tag, " ready drop"}, on8 ? ready8 : ready, 0);
    endtask

    task automatic rd_chk(input bit on8, input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        bus(on8, a, 4'b0000, 32'h0, tag, r);
        check({tag, " rdata"}, r, exp);
    endtask

    task automatic wr(input bit on8, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input string tag);
        logic [31:0] r;
        bus(on8, a, s, d, tag, r);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; valid8 = 1'b0;
        strb = '0; addr = '0; wdata = '0; gpio_in = '0; gpio_in8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", ready, 0);
        check("reset gpio_out", gout, 0);
        check("reset gpio_oe", goe, 0);
        check("reset irq", irq, 0);
        @(negedge clk) reset = 1'b0;

        rd_chk(0, 32'h0300_0000, 32'h0, "rd OUT reset");
        rd_chk(0, 32'h0300_0004, 32'h0, "rd OE reset");
        rd_chk(0, 32'h0300_0008, 32'h0, "rd IN reset");

        // Byte strobes 0101 update bytes 0 and 2 only; the write returns the old value.
        bus(0, 32'h0300_0000, 4'b0101, 32'hA5A5_1234, "wr OUT strb", rd);
        check("wr OUT old rdata", rd, 32'h0);
        check("gpio_out strb", gout, 32'h00A5_0034);
        rd_chk(0, 32'h0300_0000, 32'h00A5_0034, "rd OUT");
        rd_chk(0, 32'h037F_FFE0, 32'h00A5_0034, "rd OUT alias");

        // Unselected window: never acknowledged, no state change.
        @(negedge clk);
        addr = 32'h0200_0000; strb = 4'hF; wdata = 32'hFFFF_FFFF; valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("unselected ready", ready, 0);
        end
        valid = 1'b0;
        check("unselected gpio_out", gout, 32'h00A5_0034);

        // Held request: ready every second cycle.
        @(negedge clk);
        addr = 32'h0300_0000; strb = 4'h0; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("back-to-back ready", ready, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        valid = 1'b0;
        check("back-to-back rdata", rdata, 32'h00A5_0034);

        // A read selected on the second edge after the pin change still sees the old IN.
        @(negedge clk) gpio_in = 32'h0000_0F0F;
        rd_chk(0, 32'h0300_0008, 32'h0, "rd IN latency");
        rd_chk(0, 32'h0300_0008, 32'h0000_0F0F, "rd IN");
        wr(0, 32'h0300_0008, 4'hF, 32'hFFFF_FFFF, "wr IN");
        rd_chk(0, 32'h0300_0008, 32'h0000_0F0F, "rd IN after write");
        wr(0, 32'h0300_0018, 4'hF, 32'hFFFF_FFFF, "wr 0x18");
        rd_chk(0, 32'h0300_0018, 32'h0, "rd 0x18");
        rd_chk(0, 32'h0300_001C, 32'h0, "rd 0x1C");

        // WIDTH = 8 instance: bits above 7 read 0 and ignore writes.
        wr(1, 32'h0300_0004, 4'hF, 32'hFFFF_FFFF, "w8 wr OE");
        check("w8 gpio_oe", goe8, 32'h0000_00FF);
        rd_chk(1, 32'h0300_0004, 32'h0000_00FF, "w8 rd OE");
        wr(1, 32'h0300_0000, 4'hF, 32'h1234_5678, "w8 wr OUT");
        check("w8 gpio_out", gout8, 32'h0000_0078);

        @(negedge clk) gpio_in = 32'h0;
        repeat (4) @(posedge clk);

`ifdef PICOSOC_GPIO_IRQ_EN
        wr(0, 32'h0300_000C, 4'hF, 32'h8, "wr IRQ_EN");
        wr(0, 32'h0300_0010, 4'hF, 32'h8, "wr IRQ_EDGE");
        rd_chk(0, 32'h0300_000C, 32'h8, "rd IRQ_EN");
        rd_chk(0, 32'h0300_0010, 32'h8, "rd IRQ_EDGE");

        // Rising edge: irq follows SYNC_STAGES+1 = 3 edges after the pin change.
        @(negedge clk) gpio_in = 32'h8;
        @(posedge clk);
        @(posedge clk); #1;
        check("irq before edge latency", irq, 0);
        @(posedge clk); #1;
        check("irq rise", irq, 1);
        rd_chk(0, 32'h0300_0014, 32'h8, "rd STATUS set");

        wr(0, 32'h0300_000C, 4'hF, 32'h0, "mask IRQ_EN");
        check("irq masked", irq, 0);
        rd_chk(0, 32'h0300_0014, 32'h8, "rd STATUS masked");
        wr(0, 32'h0300_000C, 4'hF, 32'h8, "unmask IRQ_EN");
        check("irq unmasked", irq, 1);
        wr(0, 32'h0300_0014, 4'hF, 32'h8, "w1c STATUS");
        check("irq cleared", irq, 0);
        rd_chk(0, 32'h0300_0014, 32'h0, "rd STATUS cleared");

        // Falling mode: the IRQ_EDGE write alone must not raise anything.
        wr(0, 32'h0300_0010, 4'hF, 32'h0, "wr IRQ_EDGE fall");
        repeat (3) @(posedge clk);
        #1;
        check("irq edge-write quiet", irq, 0);
        @(negedge clk) gpio_in = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        check("irq falling", irq, 1);
        wr(0, 32'h0300_0014, 4'hF, 32'h8, "w1c after fall");
        check("irq cleared fall", irq, 0);
        @(negedge clk) gpio_in = 32'h8;
        repeat (4) @(posedge clk);
        #1;
        check("irq rise ignored", irq, 0);

        // W1C lands on the same edge that sets STATUS[3]: set wins.
        @(negedge clk) gpio_in = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        addr = 32'h0300_0014; strb = 4'hF; wdata = 32'h8; valid = 1'b1;
        @(posedge clk); #1;
        check("coincide ready", ready, 1);
        check("coincide irq", irq, 1);
        valid = 1'b0;
        rd_chk(0, 32'h0300_0014, 32'h8, "rd STATUS coincide");
        wr(0, 32'h0300_0014, 4'hF, 32'h8, "w1c final");
        check("irq final clear", irq, 0);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) gpio_in = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
            repeat (4) @(posedge clk);
            #1;
            check("no-irq toggle", irq, 0);
        end
        wr(0, 32'h0300_000C, 4'hF, 32'hFFFF_FFFF, "no-irq wr IRQ_EN");
        rd_chk(0, 32'h0300_000C, 32'h0, "no-irq rd IRQ_EN");
        rd_chk(0, 32'h0300_0014, 32'h0, "no-irq rd STATUS");
        check("no-irq irq", irq, 0);
`endif

        // Reset while ready is high drops it and OUT at once, without a clock edge.
        @(negedge clk);
        addr = 32'h0300_0000; strb = 4'hF; wdata = 32'hFFFF_FFFF; valid = 1'b1;
        @(posedge clk); #1;
        check("pre-reset ready", ready, 1);
        check("pre-reset gpio_out", gout, 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        check("async reset ready", ready, 0);
        check("async reset gpio_out", gout, 32'h0);
        check("async reset irq", irq, 0);
        valid = 1'b0;
        @(negedge clk) reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
